// File: rtl/fmap_pkg.sv
// rtl/fmap_pkg.sv - shared word width, signed word type and writer state encoding
package fmap_pkg;

   localparam int WORD_W = 32;

   typedef logic signed [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/fmap_writer.sv
// rtl/fmap_writer.sv - streams a captured feature map element-by-element into memory
// Optional running checksum of written words: define FMAP_WRITER_CHECKSUM_EN.
module fmap_writer
   import fmap_pkg::*;
#(
   parameter int                map_width = 5,
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic signed [map_width*map_width*WORD_W-1:0] in_map,
   output logic                                      busy,
   output logic                                      mem_we,
   output logic [ADDR_W-1:0]                         mem_addr,
   output logic signed [WORD_W-1:0]                  mem_wdata,
   input  logic                                      mem_ready,
   output logic                                      done,
   output logic [WORD_W-1:0]                         checksum
);

   localparam int N     = map_width * map_width;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   wr_state_t                 state_q;
   logic [IDX_W-1:0]          idx_q;
   logic [IDX_W-1:0]          idx_d;
   logic [N*WORD_W-1:0]       map_q;
   logic                      busy_q;
   logic                      mem_we_q;
   logic [ADDR_W-1:0]         mem_addr_q;
   word_t                     mem_wdata_q;
   logic                      done_q;
   logic                      accept;
   logic                      last;

   assign idx_d  = idx_q + IDX_W'(1);
   assign accept = (state_q == WRITE) && mem_ready;
   assign last   = (idx_q == IDX_W'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         map_q       <= '0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  map_q       <= in_map;
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= BASE_ADDR;
                  mem_wdata_q <= in_map[WORD_W-1:0];
                  state_q     <= WRITE;
               end
            end
            WRITE: begin
               // Address and data stay put until the memory takes the word.
               if (mem_ready) begin
                  if (last) begin
                     mem_we_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     idx_q       <= idx_d;
                     mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                     mem_wdata_q <= map_q[idx_d*WORD_W +: WORD_W];
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               mem_we_q <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FMAP_WRITER_CHECKSUM_EN
   logic [WORD_W-1:0] checksum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         checksum_q <= '0;
      end else if (accept) begin
         checksum_q <= checksum_q + mem_wdata_q;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign busy      = busy_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fmap_writer.sv
// tb/tb_fmap_writer.sv - directed self-checking bench for fmap_writer
module tb_fmap_writer;

   localparam int N = 25;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;

   logic                 start_a = 1'b0;
   logic signed [N*32-1:0] map_a = '0;
   logic                 ready_a = 1'b1;
   logic                 busy_a, we_a, done_a;
   logic [15:0]          addr_a;
   logic signed [31:0]   wdata_a;
   logic [31:0]          csum_a;

   logic                 start_b = 1'b0;
   logic signed [N*32-1:0] map_b = '0;
   logic                 ready_b = 1'b1;
   logic                 busy_b, we_b, done_b;
   logic [15:0]          addr_b;
   logic signed [31:0]   wdata_b;
   logic [31:0]          csum_b;

   int n_tests = 0;
   int n_fail  = 0;

   logic signed [N*32-1:0] ramp;
   logic signed [N*32-1:0] allmax;
   logic [31:0] exp_big_sum;

   fmap_writer #(.map_width(5), .ADDR_W(16), .BASE_ADDR(16'h0000)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_map(map_a),
      .busy(busy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .mem_ready(ready_a), .done(done_a), .checksum(csum_a)
   );

   fmap_writer #(.map_width(5), .ADDR_W(16), .BASE_ADDR(16'hFFF0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_map(map_b),
      .busy(busy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .mem_ready(ready_b), .done(done_b), .checksum(csum_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_a(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
      chk({tag, " we"},   {31'd0, we_a},   32'd0);
      chk({tag, " busy"}, {31'd0, busy_a}, 32'd0);
      chk({tag, " done"}, {31'd0, done_a}, 32'd0);
      chk({tag, " addr"}, {16'd0, addr_a}, exp_addr);
      chk({tag, " data"}, wdata_a, exp_data);
   endtask

   // Full ramp transfer on dut_a; caller has driven map_a with the ramp.
   task automatic xfer_a(input string tag, input int stall_idx, input int stall_len,
                         input bit poke_start, input bit change_map);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      if (change_map) map_a = allmax;
      for (int i = 0; i < N; i++) begin
         if (i == stall_idx) begin
            ready_a = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               chk({tag, " stall addr"}, {16'd0, addr_a}, 32'(i));
               chk({tag, " stall data"}, wdata_a, 32'(i - 12));
               chk({tag, " stall we"}, {31'd0, we_a}, 32'd1);
               @(negedge clk);
            end
            ready_a = 1'b1;
         end
         chk({tag, " addr"}, {16'd0, addr_a}, 32'(i));
         chk({tag, " data"}, wdata_a, 32'(i - 12));
         chk({tag, " we"},   {31'd0, we_a},   32'd1);
         chk({tag, " busy"}, {31'd0, busy_a}, 32'd1);
         chk({tag, " done"}, {31'd0, done_a}, 32'd0);
         if (poke_start) start_a = (i == 5);
         @(negedge clk);
      end
      chk({tag, " done pulse"}, {31'd0, done_a}, 32'd1);
      chk({tag, " done we"},    {31'd0, we_a},   32'd0);
      chk({tag, " done busy"},  {31'd0, busy_a}, 32'd1);
      chk({tag, " checksum"},   csum_a, 32'd0);
      if (poke_start) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk_idle_a({tag, " after"}, 32'd24, 32'd12);
      @(negedge clk);
      chk_idle_a({tag, " after2"}, 32'd24, 32'd12);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         ramp[i*32 +: 32]   = 32'(i - 12);
         allmax[i*32 +: 32] = 32'h7FFF_FFFF;
      end
`ifdef FMAP_WRITER_CHECKSUM_EN
      exp_big_sum = 32'h7FFF_FFE7;
`else
      exp_big_sum = 32'h0000_0000;
`endif

      // reset state
      #1;
      chk_idle_a("reset", 32'd0, 32'd0);
      chk("reset csum", csum_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // plain transfer
      map_a = ramp;
      xfer_a("plain", -1, 0, 1'b0, 1'b0);

      // back-pressure on element 7
      map_a = ramp;
      xfer_a("stall", 7, 3, 1'b0, 1'b0);

      // start pulses during WRITE and DONE ignored
      map_a = ramp;
      xfer_a("poke", -1, 0, 1'b1, 1'b0);

      // input changed right after capture
      map_a = ramp;
      xfer_a("capture", -1, 0, 1'b0, 1'b1);

      // reset after the 10th accepted write
      map_a = ramp;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("abort pre addr", {16'd0, addr_a}, 32'(i));
         @(negedge clk);
      end
      chk("abort idx10 addr", {16'd0, addr_a}, 32'd10);
      rst = 1'b1;
      #1;
      chk_idle_a("abort rst", 32'd0, 32'd0);
      chk("abort csum", csum_a, 32'd0);
      @(negedge clk);
      chk("abort no done", {31'd0, done_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk_idle_a("abort wait", 32'd0, 32'd0);
      @(negedge clk);
      chk("abort still idle", {31'd0, busy_a}, 32'd0);
      xfer_a("restart", -1, 0, 1'b0, 1'b0);

      // address wrap with BASE_ADDR=FFF0
      map_b = allmax;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk("wrap addr", {16'd0, addr_b}, {16'd0, 16'(16'hFFF0 + i)});
         chk("wrap data", wdata_b, 32'h7FFF_FFFF);
         chk("wrap we",   {31'd0, we_b}, 32'd1);
         @(negedge clk);
      end
      chk("wrap done", {31'd0, done_b}, 32'd1);
      chk("wrap csum", csum_b, exp_big_sum);
      @(negedge clk);
      chk("wrap idle busy", {31'd0, busy_b}, 32'd0);
      chk("wrap hold addr", {16'd0, addr_b}, 32'h0000_0008);
      chk("wrap hold csum", csum_b, exp_big_sum);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
